xorwow_multi_axil: RTL and testbench
====================================

XORWOW_MULTI_AXIL -- requirements
Module: xorwow_multi_axil

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent xorwow generator channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, per-channel output FIFO depth (power of 2, 2..64).
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (fixed at 32).
REQ-004 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, AXI4-Lite byte address width.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR/3/1/1  write address channel.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR/3/1/1  read address channel.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- irq  out  1  level interrupt; present only with XORWOW_IRQ_EN.

Function
REQ-006 SHALL implement the register map: 0x00 CTRL RW, 0x04 SEED WO, 0x08 STATUS RO/W1C, 0x0C DATA RO-pop, 0x10 ID RO = 0x5852_0200; other addresses read 0, writes ignored.
REQ-007 SHALL decode CTRL as: [0] EN; [1] SEED_LOAD (self-clearing pulse, reads 0); [2] FLUSH (self-clearing pulse, reads 0); [6:4] CH_SEL; [15:8] IRQ_THR.
REQ-008 SHALL accept a write only when AWVALID and WVALID are both high, with AWREADY/WREADY pulsing for 1 cycle, BVALID the next cycle held until BREADY, and one outstanding write.
REQ-009 SHALL pulse ARREADY for 1 cycle on ARVALID, drive RVALID the next cycle holding RDATA stable until RREADY, and allow one outstanding read.
REQ-010 SHALL return RESP=OKAY (2'b00) for every access; WSTRB byte lanes SHALL gate CTRL writes.
REQ-011 SHALL implement the per-channel state x,y,z,w,v,d (32 b each) with one step: t=x^(x>>2); x<=y; y<=z; z<=w; w<=v; v<=v^(v<<4)^t^(t<<1); d<=d+362437 (mod 2^32); pushed word = d_new+v_new.
REQ-012 SHALL step each channel at most once per cycle, only when EN=1 and its FIFO is not full, or is full with a pop in the same cycle.
REQ-013 SHALL, on a DATA read handshake, return the head of FIFO[CH_SEL] and pop it; on an empty FIFO it SHALL return 0, not pop, and set STATUS[10] UNDERFLOW (sticky).
REQ-014 SHALL report STATUS[7:0] = level of FIFO[CH_SEL], [8] empty, [9] full, [10] underflow; writing 1 to bit 10 SHALL clear it.
REQ-015 SHALL push each SEED write into a 6-word staging buffer in order x,y,z,w,v,d at an index that wraps 5->0.
REQ-016 SHALL, on SEED_LOAD, copy the staging buffer to channel CH_SEL, empty that FIFO, and reset the index to 0; the load SHALL override a same-cycle step or push on that channel.
REQ-017 SHALL, on FLUSH, empty FIFO[CH_SEL]; a same-cycle push SHALL be dropped.
REQ-018 SHALL fill an empty FIFO in FIFO_DEPTH consecutive cycles after EN rises; clearing EN SHALL freeze the state and keep the FIFO contents.

Reset
REQ-019 SHALL, while s00_axi_aresetn=0, drive all ready/valid outputs and irq to 0, RDATA to 0, CTRL to 0, empty all FIFOs, clear UNDERFLOW, and zero the staging index.
REQ-020 SHALL reset every channel to x=123456789, y=362436069, z=521288629, w=88675123, v=5783321, d=6615241 XOR channel index.
REQ-021 SHALL abort an in-flight transaction on reset with no response issued.

Configuration
REQ-022 SHALL, with XORWOW_IRQ_EN defined, drive irq=1 while any channel FIFO level >= IRQ_THR and IRQ_THR != 0, registered with 1-cycle latency.
REQ-023 SHALL, without XORWOW_IRQ_EN, omit the irq port, treat CTRL[15:8] as read-zero, and omit the comparison logic.

Structure
REQ-024 SHALL place the register offsets, CTRL/STATUS bit positions, the ID constant, the reset seed constants, the increment 362437, and the state-record typedef in package xorwow_multi_pkg.
REQ-025 SHALL implement one generator plus FIFO in sub-module xorwow_chan, instantiated N_CH times by generate.

Verification
REQ-026 SHALL verify: reset, then read ID and STATUS -> 0x5852_0200, then 0x0000_0100 (empty).
REQ-027 SHALL verify: write CTRL=0x1, wait 10 cycles, read STATUS -> level 4, full=1; four DATA reads match the software model for the default seed; the fifth read is not 0-with-underflow because refill continues.
REQ-028 SHALL verify: EN=0, read DATA on an empty FIFO -> RDATA=0, STATUS[10]=1; write STATUS 0x400 -> bit clears.
REQ-029 SHALL verify: write seed 1,2,3,4,5,6, then CTRL=0x12 (SEED_LOAD, CH 1) -> channel 1 sequence matches the model from that seed, and channels 0/2/3 are unaffected.
REQ-030 SHALL verify: with XORWOW_IRQ_EN, CTRL=0x0000_0301 -> irq rises 4 cycles after EN (3 fills + 1 register); draining to level 2 with EN=0 drops irq.
REQ-031 SHALL verify: assert reset mid-burst with ARVALID held -> RVALID=0, FIFOs empty, CTRL=0 after release.

Source files
------------

// File: rtl/xorwow_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xorwow_multi_pkg
//  Description : Shared constants, state record and step helpers for the
//                multi-channel xorwow generator with AXI4-Lite access.
//  Revision    : 1.0 - initial release
// ============================================================================
package xorwow_multi_pkg;

    // Register byte offsets
    localparam logic [31:0] c_reg_ctrl   = 32'h0000_0000;
    localparam logic [31:0] c_reg_seed   = 32'h0000_0004;
    localparam logic [31:0] c_reg_status = 32'h0000_0008;
    localparam logic [31:0] c_reg_data   = 32'h0000_000C;
    localparam logic [31:0] c_reg_id     = 32'h0000_0010;

    // CTRL bit positions
    localparam int c_ctrl_en        = 0;
    localparam int c_ctrl_seed_load = 1;
    localparam int c_ctrl_flush     = 2;
    localparam int c_ctrl_ch_lsb    = 4;
    localparam int c_ctrl_ch_msb    = 6;
    localparam int c_ctrl_thr_lsb   = 8;
    localparam int c_ctrl_thr_msb   = 15;

    // STATUS bit positions (level occupies [7:0])
    localparam int c_stat_empty     = 8;
    localparam int c_stat_full      = 9;
    localparam int c_stat_underflow = 10;

    localparam logic [31:0] c_id_value = 32'h5852_0200;

    // Reset seed and Weyl increment
    localparam logic [31:0] c_seed_x = 32'd123456789;
    localparam logic [31:0] c_seed_y = 32'd362436069;
    localparam logic [31:0] c_seed_z = 32'd521288629;
    localparam logic [31:0] c_seed_w = 32'd88675123;
    localparam logic [31:0] c_seed_v = 32'd5783321;
    localparam logic [31:0] c_seed_d = 32'd6615241;
    localparam logic [31:0] c_xw_inc = 32'd362437;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] d;
    } xw_state_t;

    // Power-on state of a channel; d is decorrelated by the channel index
    function automatic xw_state_t xw_seed(input logic [2:0] ch);
        xw_state_t s;
        s.x = c_seed_x;
        s.y = c_seed_y;
        s.z = c_seed_z;
        s.w = c_seed_w;
        s.v = c_seed_v;
        s.d = c_seed_d ^ {29'b0, ch};
        return s;
    endfunction

    // One xorwow step
    function automatic xw_state_t xw_step(input xw_state_t s);
        xw_state_t   n;
        logic [31:0] t;
        t   = s.x ^ (s.x >> 2);
        n.x = s.y;
        n.y = s.z;
        n.z = s.w;
        n.w = s.v;
        n.v = s.v ^ (s.v << 4) ^ t ^ (t << 1);
        n.d = s.d + c_xw_inc;
        return n;
    endfunction

    // Output word of an already-stepped state
    function automatic logic [31:0] xw_word(input xw_state_t s);
        return s.d + s.v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xorwow_multi_axil_chan.sv
`default_nettype none
// ============================================================================
//  Module      : xorwow_chan
//  Description : One xorwow generator feeding its own output FIFO. Steps
//                whenever enabled and the FIFO can accept a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module xorwow_chan
    import xorwow_multi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CH_IDX     = 0,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic [191:0]       i_load_state,
    output logic [31:0]        o_head,
    output logic [LVL_W-1:0]   o_level,
    output logic               o_empty,
    output logic               o_full
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    xw_state_t            r_state;
    xw_state_t            w_next;
    xw_state_t            w_load_state;
    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_step;
    logic                 w_push;

    assign w_load_state = xw_state_t'(i_load_state);
    assign w_next       = xw_step(r_state);
    assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty      = (r_level == '0);
    assign w_pop        = i_pop && !w_empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still step
    assign w_step       = i_en && (!w_full || w_pop);
    // Load and flush both empty the FIFO, so the stepped word is discarded
    assign w_push       = w_step && !i_flush && !i_load;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = w_empty;
    assign o_full  = w_full;

    // Generator state: a seed load overrides any step in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= xw_seed(3'(CH_IDX));
        end else if (i_load) begin
            r_state <= w_load_state;
        end else if (w_step) begin
            r_state <= w_next;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_load || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= xw_word(w_next);
    end

endmodule
`default_nettype wire

// File: rtl/xorwow_multi_axil.sv
`default_nettype none
// ============================================================================
//  Module      : xorwow_multi_axil
//  Description : N_CH independent xorwow generators with per-channel output
//                FIFOs, controlled and drained over an AXI4-Lite slave.
//                Define XORWOW_IRQ_EN to add the FIFO-level interrupt output
//                and the CTRL[15:8] threshold field.
//  Revision    : 1.0 - initial release
// ============================================================================
module xorwow_multi_axil
    import xorwow_multi_pkg::*;
#(
    parameter int N_CH               = 4,
    parameter int FIFO_DEPTH         = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
`ifdef XORWOW_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                          r_en;
    logic [2:0]                    r_ch_sel;
    logic                          r_load_pulse;
    logic                          r_flush_pulse;
    logic                          r_underflow;
    logic [31:0]                   r_seed_buf [6];
    logic [2:0]                    r_seed_idx;
    logic [7:0]                    w_thr_rd;

    logic                          w_wr_fire;
    logic                          w_rd_fire;
    logic [31:0]                   w_wr_addr;
    logic [31:0]                   w_rd_addr;
    logic                          w_wr_ctrl;
    logic                          w_wr_seed;
    logic                          w_wr_status;
    logic                          w_rd_data;
    logic                          w_data_pop;
    logic [31:0]                   w_rd_word;
    logic [191:0]                  w_load_state;

    logic [31:0]                   w_head  [N_CH];
    logic [c_lvl_w-1:0]            w_lvl   [N_CH];
    logic [N_CH-1:0]               w_empty;
    logic [N_CH-1:0]               w_full;
    logic [31:0]                   w_sel_head;
    logic [c_lvl_w-1:0]            w_sel_lvl;
    logic                          w_sel_empty;
    logic                          w_sel_full;

    logic                          w_unused;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb};

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;

    assign w_wr_fire   = r_awready && s00_axi_awvalid && s00_axi_wvalid;
    assign w_rd_fire   = r_arready && s00_axi_arvalid;
    assign w_wr_addr   = 32'(s00_axi_awaddr) & ~32'h3;
    assign w_rd_addr   = 32'(s00_axi_araddr) & ~32'h3;
    assign w_wr_ctrl   = w_wr_fire && (w_wr_addr == c_reg_ctrl);
    assign w_wr_seed   = w_wr_fire && (w_wr_addr == c_reg_seed);
    assign w_wr_status = w_wr_fire && (w_wr_addr == c_reg_status);
    assign w_rd_data   = w_rd_fire && (w_rd_addr == c_reg_data);
    assign w_data_pop  = w_rd_data && !w_sel_empty;

    assign w_load_state = {r_seed_buf[0], r_seed_buf[1], r_seed_buf[2],
                           r_seed_buf[3], r_seed_buf[4], r_seed_buf[5]};

    // Write channel: ready pulses once both address and data are present
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            if (!r_awready && !r_bvalid && s00_axi_awvalid && s00_axi_wvalid) begin
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data captured at the address handshake, held until taken
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= 1'b0;
            if (!r_arready && !r_rvalid && s00_axi_arvalid) begin
                r_arready <= 1'b1;
            end
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= C_S_AXI_DATA_WIDTH'(w_rd_word);
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // CTRL register; load/flush are registered so they act on the new CH_SEL
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_en          <= 1'b0;
            r_ch_sel      <= 3'd0;
            r_load_pulse  <= 1'b0;
            r_flush_pulse <= 1'b0;
        end else begin
            r_load_pulse  <= 1'b0;
            r_flush_pulse <= 1'b0;
            if (w_wr_ctrl && s00_axi_wstrb[0]) begin
                r_en          <= s00_axi_wdata[c_ctrl_en];
                r_ch_sel      <= s00_axi_wdata[c_ctrl_ch_msb:c_ctrl_ch_lsb];
                r_load_pulse  <= s00_axi_wdata[c_ctrl_seed_load];
                r_flush_pulse <= s00_axi_wdata[c_ctrl_flush];
            end
        end
    end

    // Seed staging buffer filled in x,y,z,w,v,d order
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_seed_idx <= 3'd0;
            for (int i = 0; i < 6; i++) r_seed_buf[i] <= '0;
        end else if (r_load_pulse) begin
            r_seed_idx <= 3'd0;
        end else if (w_wr_seed) begin
            r_seed_buf[r_seed_idx] <= s00_axi_wdata[31:0];
            r_seed_idx             <= (r_seed_idx == 3'd5) ? 3'd0 : r_seed_idx + 3'd1;
        end
    end

    // Sticky underflow flag, cleared by writing 1
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_underflow <= 1'b0;
        end else if (w_rd_data && w_sel_empty) begin
            r_underflow <= 1'b1;
        end else if (w_wr_status && s00_axi_wdata[c_stat_underflow]) begin
            r_underflow <= 1'b0;
        end
    end

    // Selected-channel view; an out-of-range CH_SEL looks like an empty FIFO
    always_comb begin
        w_sel_head  = '0;
        w_sel_lvl   = '0;
        w_sel_empty = 1'b1;
        w_sel_full  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch_sel == 3'(i)) begin
                w_sel_head  = w_head[i];
                w_sel_lvl   = w_lvl[i];
                w_sel_empty = w_empty[i];
                w_sel_full  = w_full[i];
            end
        end
    end

    // Register read mux
    always_comb begin
        w_rd_word = '0;
        case (w_rd_addr)
            c_reg_ctrl:   w_rd_word = {16'h0, w_thr_rd, 1'b0, r_ch_sel, 3'b000, r_en};
            c_reg_status: w_rd_word = {21'h0, r_underflow, w_sel_full, w_sel_empty, 8'(w_sel_lvl)};
            c_reg_data:   w_rd_word = w_sel_empty ? 32'h0 : w_sel_head;
            c_reg_id:     w_rd_word = c_id_value;
            default:      w_rd_word = '0;
        endcase
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        xorwow_chan #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .CH_IDX     (gi)
        ) u_chan (
            .clk          (s00_axi_aclk),
            .rst_n        (s00_axi_aresetn),
            .i_en         (r_en),
            .i_pop        (w_data_pop && (r_ch_sel == 3'(gi))),
            .i_flush      (r_flush_pulse && (r_ch_sel == 3'(gi))),
            .i_load       (r_load_pulse && (r_ch_sel == 3'(gi))),
            .i_load_state (w_load_state),
            .o_head       (w_head[gi]),
            .o_level      (w_lvl[gi]),
            .o_empty      (w_empty[gi]),
            .o_full       (w_full[gi])
        );
    end

`ifdef XORWOW_IRQ_EN
    logic [7:0] r_irq_thr;
    logic       r_irq;
    logic       w_irq_hit;

    assign w_thr_rd = r_irq_thr;
    assign irq      = r_irq;

    // Threshold lives in the second CTRL byte lane
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_irq_thr <= 8'h00;
        end else if (w_wr_ctrl && s00_axi_wstrb[1]) begin
            r_irq_thr <= s00_axi_wdata[c_ctrl_thr_msb:c_ctrl_thr_lsb];
        end
    end

    // Any channel at or above a non-zero threshold raises the interrupt
    always_comb begin
        w_irq_hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (8'(w_lvl[i]) >= r_irq_thr) w_irq_hit = 1'b1;
        end
        if (r_irq_thr == 8'h00) w_irq_hit = 1'b0;
    end

    // Registered interrupt level
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_hit;
        end
    end
`else
    assign w_thr_rd = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xorwow_multi_axil.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xorwow_multi_axil
//  Description : Directed self-checking bench for xorwow_multi_axil.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xorwow_multi_axil;

    localparam logic [4:0] c_a_ctrl   = 5'h00;
    localparam logic [4:0] c_a_seed   = 5'h04;
    localparam logic [4:0] c_a_status = 5'h08;
    localparam logic [4:0] c_a_data   = 5'h0C;
    localparam logic [4:0] c_a_id     = 5'h10;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef XORWOW_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    // Reference generator state
    logic [31:0] mx, my, mz, mw, mv, md;

    always #5 clk = ~clk;

    xorwow_multi_axil #(
        .N_CH               (4),
        .FIFO_DEPTH         (4),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
`ifdef XORWOW_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_load(input logic [31:0] x, y, z, w, v, d);
        mx = x; my = y; mz = z; mw = w; mv = v; md = d;
    endtask

    task automatic m_next(output logic [31:0] word);
        logic [31:0] t;
        t  = mx ^ (mx >> 2);
        mx = my;
        my = mz;
        mz = mw;
        mw = mv;
        mv = mv ^ (mv << 4) ^ t ^ (t << 1);
        md = md + 32'd362437;
        word = md + mv;
    endtask

    task automatic m_default(input int ch);
        m_load(32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123,
               32'd5783321, 32'd6615241 ^ 32'(ch));
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
        check("aw_handshake", {31'b0, awready}, 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk);
        check("bvalid_seen", {31'b0, bvalid}, 32'd1);
        check("bresp_okay", {30'b0, bresp}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 20 && !arready; n++) @(negedge clk);
        check("ar_handshake", {31'b0, arready}, 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
        check("rvalid_seen", {31'b0, rvalid}, 32'd1);
        d = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
    endtask

    // Absolute time limit
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset state of the bus outputs
        repeat (3) @(negedge clk);
        check("rst_ready_valid", {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;

        // Identification and idle status
        axi_read(c_a_id, rd);     check("id", rd, 32'h5852_0200);
        axi_read(c_a_status, rd); check("status_reset", rd, 32'h0000_0100);
        axi_read(5'h14, rd);      check("unmapped_read", rd, 32'h0);

`ifdef XORWOW_IRQ_EN
        // Threshold 3: irq appears four cycles after EN is written
        check("irq_reset", {31'b0, irq}, 32'd0);
        axi_write(c_a_ctrl, 32'h0000_0301, 4'hF);
        check("irq_lvl1", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("irq_lvl3_pre", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_rise", {31'b0, irq}, 32'd1);
        // Drain every channel to level 2 with EN off
        for (int ch = 0; ch < 4; ch++) begin
            axi_write(c_a_ctrl, 32'h0000_0300 | (32'(ch) << 4), 4'hF);
            axi_read(c_a_data, rd);
            axi_read(c_a_data, rd);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("irq_drop", {31'b0, irq}, 32'd0);
        pulse_reset();
`endif

        // Enable channel generation and let channel 0 fill
        axi_write(c_a_ctrl, 32'h0000_0001, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        axi_read(c_a_status, rd); check("status_full", rd, 32'h0000_0204);
        m_default(0);
        for (int k = 0; k < 5; k++) begin
            m_next(exp);
            axi_read(c_a_data, rd);
            check($sformatf("ch0_word%0d", k), rd, exp);
        end
        axi_read(c_a_status, rd); check("status_refilled", rd, 32'h0000_0204);

        // Flush with EN off, then underflow and its clear
        axi_write(c_a_ctrl, 32'h0000_0004, 4'hF);
        axi_read(c_a_ctrl, rd);   check("ctrl_flush_selfclear", rd, 32'h0);
        axi_read(c_a_status, rd); check("status_flushed", rd, 32'h0000_0100);
        axi_read(c_a_data, rd);   check("data_empty_zero", rd, 32'h0);
        axi_read(c_a_status, rd); check("status_underflow", rd, 32'h0000_0500);
        axi_write(c_a_status, 32'h0000_0400, 4'hF);
        axi_read(c_a_status, rd); check("status_uf_cleared", rd, 32'h0000_0100);

        // Zero byte strobes leave CTRL untouched
        axi_write(c_a_ctrl, 32'h0000_0031, 4'h0);
        axi_read(c_a_ctrl, rd);   check("ctrl_wstrb_gate", rd, 32'h0);

        // Seed channel 1 with 1..6
        for (int k = 1; k <= 6; k++) axi_write(c_a_seed, 32'(k), 4'hF);
        axi_write(c_a_ctrl, 32'h0000_0012, 4'hF);
        axi_read(c_a_ctrl, rd);   check("ctrl_load_selfclear", rd, 32'h0000_0010);
        axi_read(c_a_status, rd); check("status_ch1_loaded", rd, 32'h0000_0100);
        axi_write(c_a_ctrl, 32'h0000_0011, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        axi_write(c_a_ctrl, 32'h0000_0010, 4'hF);
        axi_read(c_a_status, rd); check("status_ch1_full", rd, 32'h0000_0204);
        m_load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
        for (int k = 0; k < 4; k++) begin
            m_next(exp);
            axi_read(c_a_data, rd);
            check($sformatf("ch1_word%0d", k), rd, exp);
        end
        axi_read(c_a_status, rd); check("status_ch1_drained", rd, 32'h0000_0100);

        // Channels 2 and 3 still hold their first default-seed words
        axi_write(c_a_ctrl, 32'h0000_0020, 4'hF);
        axi_read(c_a_status, rd); check("status_ch2_full", rd, 32'h0000_0204);
        m_default(2);
        for (int k = 0; k < 4; k++) begin
            m_next(exp);
            axi_read(c_a_data, rd);
            check($sformatf("ch2_word%0d", k), rd, exp);
        end
        axi_write(c_a_ctrl, 32'h0000_0030, 4'hF);
        m_default(3);
        m_next(exp);
        axi_read(c_a_data, rd);   check("ch3_word0", rd, exp);

        // Reset in the middle of a read with ARVALID held
        axi_write(c_a_ctrl, 32'h0000_0001, 4'hF);
        repeat (6) @(posedge clk);
        @(negedge clk);
        araddr  = c_a_data;
        arvalid = 1'b1;
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        check("midrst_arready_rvalid", {30'b0, arready, rvalid}, 32'd0);
        repeat (2) @(negedge clk);
        arvalid = 1'b0;
        aresetn = 1'b1;
        @(negedge clk);
        check("postrst_rvalid", {31'b0, rvalid}, 32'd0);
        axi_read(c_a_ctrl, rd);   check("postrst_ctrl", rd, 32'h0);
        axi_read(c_a_status, rd); check("postrst_status_ch0", rd, 32'h0000_0100);
        axi_write(c_a_ctrl, 32'h0000_0020, 4'hF);
        axi_read(c_a_status, rd); check("postrst_status_ch2", rd, 32'h0000_0100);
`ifdef XORWOW_IRQ_EN
        check("postrst_irq", {31'b0, irq}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
